// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronising local LFSR with lock tracking, error pulse and saturating error count.
// Optional all-zero lock-up detection is enabled by defining PRBS_CHK_ZERO_DET_EN.
module prbs_checker #(
  parameter int unsigned N        = 3,
  parameter int unsigned TAP_A    = 3,
  parameter int unsigned TAP_B    = 2,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             zero_stuck
);

  localparam int unsigned FILL_W  = $clog2(N + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  state_t             state;
  logic [1:N]         sr;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;

  logic       pred_c;
  logic       match_c;
  logic [1:N] shift_in_c;
  logic [1:N] shift_pred_c;

  // Next reference bit from the local LFSR and the two shift candidates.
  always_comb begin
    pred_c       = sr[TAP_A] ^ sr[TAP_B];
    match_c      = (bit_in == pred_c);
    shift_in_c   = {bit_in, sr[1:N-1]};
    shift_pred_c = {pred_c, sr[1:N-1]};
  end

`ifdef PRBS_CHK_ZERO_DET_EN
  logic [FILL_W-1:0] zero_cnt;
`else
  assign zero_stuck = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEED;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
`ifdef PRBS_CHK_ZERO_DET_EN
      zero_cnt   <= '0;
      zero_stuck <= 1'b0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (err_clr) begin
        err_cnt <= '0;
      end
      if (bit_valid) begin
        case (state)
          SEED: begin
            sr <= shift_in_c;
            if (fill_cnt == FILL_W'(N - 1)) begin
              state     <= HUNT;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
          HUNT: begin
            sr <= shift_in_c;
            if (!match_c) begin
              match_cnt <= '0;
            end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + MATCH_W'(1);
            end
          end
          LOCKED: begin
            // Free-running reference: a flipped input bit never enters sr.
            sr <= shift_pred_c;
            if (match_c) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (!err_clr && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
              if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                state     <= HUNT;
                locked    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                sr        <= shift_in_c;
              end else begin
                miss_cnt <= miss_cnt + MISS_W'(1);
              end
            end
          end
          default: begin
            state  <= SEED;
            locked <= 1'b0;
          end
        endcase
`ifdef PRBS_CHK_ZERO_DET_EN
        // N consecutive zeros is the LFSR lock-up pattern: restart from SEED.
        if (bit_in) begin
          zero_cnt <= '0;
        end else if (zero_cnt >= FILL_W'(N - 1)) begin
          zero_cnt   <= FILL_W'(N);
          zero_stuck <= 1'b1;
          state      <= SEED;
          locked     <= 1'b0;
          fill_cnt   <= '0;
          match_cnt  <= '0;
          miss_cnt   <= '0;
        end else begin
          zero_cnt <= zero_cnt + FILL_W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single/burst errors, clear, saturation (ERR_W=4 instance), zero detect, reset.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        bit_in;
  logic        err_clr;
  logic        locked, err_pulse, zero_stuck;
  logic [15:0] err_cnt;
  logic        locked4, err_pulse4, zero_stuck4;
  logic [3:0]  err_cnt4;

  int checks  = 0;
  int errors  = 0;
  int k       = 0;
  int pulses  = 0;
  int pulses4 = 0;
  logic pat [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .zero_stuck(zero_stuck)
  );

  prbs_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .zero_stuck(zero_stuck4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One valid bit; returns 1 time unit after the sampling edge.
  task automatic send(input logic b, input logic clr);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    err_clr   = clr;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    err_clr   = 1'b0;
    if (err_pulse)  pulses++;
    if (err_pulse4) pulses4++;
  endtask

  task automatic send_gen(input logic flip, input logic clr);
    send(pat[k % 7] ^ flip, clr);
    k++;
  endtask

  initial begin
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_zero_stuck", 32'(zero_stuck), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Clean stream: lock after the 7th bit
    repeat (6) send_gen(1'b0, 1'b0);
    check("t1_not_locked_6", 32'(locked), 32'd0);
    send_gen(1'b0, 1'b0);
    check("t1_locked_7", 32'(locked), 32'd1);
    repeat (93) send_gen(1'b0, 1'b0);
    check("t1_no_pulses", 32'(pulses), 32'd0);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t1_locked_100", 32'(locked), 32'd1);

    // Single flipped bit
    send_gen(1'b1, 1'b0);
    check("t2_pulse", 32'(err_pulse), 32'd1);
    check("t2_err_cnt", 32'(err_cnt), 32'd1);
    check("t2_locked", 32'(locked), 32'd1);
    send_gen(1'b0, 1'b0);
    check("t2_pulse_gone", 32'(err_pulse), 32'd0);
    check("t2_err_cnt_hold", 32'(err_cnt), 32'd1);

    // Flip then an idle cycle: nothing advances
    send_gen(1'b1, 1'b0);
    check("idle_pre_cnt", 32'(err_cnt), 32'd2);
    @(posedge clk);
    #1;
    check("idle_pulse", 32'(err_pulse), 32'd0);
    check("idle_err_cnt", 32'(err_cnt), 32'd2);
    check("idle_locked", 32'(locked), 32'd1);
    send_gen(1'b0, 1'b1);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Burst of three errors drops lock; relock after bad bit leaves sr
    repeat (2) send_gen(1'b1, 1'b0);
    check("t3_locked_2", 32'(locked), 32'd1);
    check("t3_err_cnt_2", 32'(err_cnt), 32'd2);
    send_gen(1'b1, 1'b0);
    check("t3_unlocked", 32'(locked), 32'd0);
    check("t3_err_cnt_3", 32'(err_cnt), 32'd3);
    pulses = 0;
    repeat (6) send_gen(1'b0, 1'b0);
    check("t3_hunt_6", 32'(locked), 32'd0);
    send_gen(1'b0, 1'b0);
    check("t3_relocked", 32'(locked), 32'd1);
    check("t3_err_cnt_kept", 32'(err_cnt), 32'd3);
    check("t3_hunt_no_pulse", 32'(pulses), 32'd0);

    // Clear together with an error
    send_gen(1'b1, 1'b1);
    check("t4_pulse", 32'(err_pulse), 32'd1);
    check("t4_err_cnt", 32'(err_cnt), 32'd0);
    check("t4_locked", 32'(locked), 32'd1);
    check("t4_err_cnt4", 32'(err_cnt4), 32'd0);

    // Saturation on the 4-bit instance (flip only 0 bits to avoid zero runs)
    pulses4 = 0;
    for (int f = 0; f < 20; f++) begin
      while (pat[k % 7] != 1'b0) send_gen(1'b0, 1'b0);
      send_gen(1'b1, 1'b0);
      if (f == 15) begin
        check("t5_sat_pulse", 32'(err_pulse4), 32'd1);
        check("t5_sat_hold", 32'(err_cnt4), 32'd15);
      end
      repeat (4) send_gen(1'b0, 1'b0);
    end
    check("t5_err_cnt4", 32'(err_cnt4), 32'd15);
    check("t5_pulses4", 32'(pulses4), 32'd20);
    check("t5_err_cnt16", 32'(err_cnt), 32'd20);
    check("t5_locked4", 32'(locked4), 32'd1);

    // Constant zeros after a 1
    while (pat[(k + 6) % 7] != 1'b1) send_gen(1'b0, 1'b0);
    repeat (2) send(1'b0, 1'b0);
    check("t6_locked_2z", 32'(locked), 32'd1);
    check("t6_zero_2z", 32'(zero_stuck), 32'd0);
    send(1'b0, 1'b0);
`ifdef PRBS_CHK_ZERO_DET_EN
    check("t6_zero_stuck", 32'(zero_stuck), 32'd1);
    check("t6_zero_unlock", 32'(locked), 32'd0);
`else
    check("t6_zero_tied", 32'(zero_stuck), 32'd0);
`endif

    // Reset asserted mid-lock with a live error pulse
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    k = 0;
    repeat (7) send_gen(1'b0, 1'b0);
    check("t7_locked", 32'(locked), 32'd1);
    check("t7_zero_cleared", 32'(zero_stuck), 32'd0);
    send_gen(1'b1, 1'b0);
    check("t7_pulse", 32'(err_pulse), 32'd1);
    check("t7_err_cnt", 32'(err_cnt), 32'd1);
    rst = 1'b0;
    #1;
    check("t7_rst_locked", 32'(locked), 32'd0);
    check("t7_rst_pulse", 32'(err_pulse), 32'd0);
    check("t7_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("t7_rst_zero", 32'(zero_stuck), 32'd0);
    @(posedge clk);
    #1;
    check("t7_rst_hold_pulse", 32'(err_pulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
